// File: rtl/spi_arb.sv
// spi_arb: two-requester round-robin arbiter in front of a single SPI_mstr16.
// A grant latches the winner's command, strobes the master, waits for its
// done (or a timeout), returns the read data to the owner and then enforces
// an idle gap before the next arbitration.
module spi_arb #(
  parameter int GAP_CYC = 4,     // idle cycles between transactions, 1..255
  parameter int TMO_CYC = 1024   // XFER cycles before abort, 2..65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        tmo_err,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        mstr_done,
  input  logic [15:0] mstr_rd_data,
  input  logic        mstr_SS_n,
  output logic        SS0_n,
  output logic        SS1_n
);

  typedef enum logic [1:0] {IDLE, LAUNCH, XFER, GAP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state, nxt;
  logic [15:0] tmo_cnt;
  logic [7:0]  gap_cnt;
  logic        owner, last_owner;
  logic        any_req, sel, grant, finish, tmo_hit, active;

  assign any_req = req0 | req1;
  // On a tie the requester that did not own the bus last time wins.
  assign sel     = (req0 & req1) ? ~last_owner : req1;
  assign tmo_hit = (tmo_cnt >= TMO_LAST);
  assign active  = (state == LAUNCH) || (state == XFER);

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    nxt    = state;
    grant  = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant = 1'b1;
          nxt   = LAUNCH;
        end
      end
      LAUNCH: nxt = XFER;
      XFER: begin
        if (mstr_done || tmo_hit) begin
          finish = 1'b1;
          nxt    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State register plus the XFER timeout and GAP counters (both zero outside
  // their state, so each starts from 0 on entry).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= 16'd0;
      gap_cnt <= 8'd0;
    end else begin
      state <= nxt;
      if (state == XFER)
        tmo_cnt <= (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
      else
        tmo_cnt <= 16'd0;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  // Grant side: one-cycle gnt pulse, command latch, ownership, and the wrt
  // strobe which fires in the cycle after the grant pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      wrt        <= 1'b0;
      cmd        <= 16'h0000;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      gnt0 <= grant & ~sel;
      gnt1 <= grant & sel;
      wrt  <= (state == LAUNCH);
      if (grant) begin
        cmd        <= sel ? cmd1 : cmd0;
        owner      <= sel;
        last_owner <= sel;
      end
    end
  end

  // Completion side: master done beats a same-cycle timeout; a timeout
  // returns zero data and sets the sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      rd_data <= 16'h0000;
      tmo_err <= 1'b0;
    end else begin
      done0 <= finish & ~owner;
      done1 <= finish & owner;
      if (finish) begin
        rd_data <= mstr_done ? mstr_rd_data : 16'h0000;
        if (!mstr_done) tmo_err <= 1'b1;
      end
    end
  end

  // Slave selects follow the master only for the current owner while the
  // transfer is live.
  assign SS0_n = (active && !owner) ? mstr_SS_n : 1'b1;
  assign SS1_n = (active &&  owner) ? mstr_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed table plus hand sequences for spi_arb. u_dut uses the
// default timeout; u_tmo (TMO_CYC=16) shares the stimulus for timeout cases.
module tb_spi_arb;

  logic        clk, rst_n, req0, req1, mstr_done, mstr_SS_n;
  logic [15:0] cmd0, cmd1, mstr_rd_data;

  logic        gnt0, gnt1, done0, done1, tmo_err, wrt, SS0_n, SS1_n;
  logic [15:0] rd_data, cmd;
  logic        t_gnt0, t_gnt1, t_done0, t_done1, t_tmo_err, t_wrt, t_SS0_n, t_SS1_n;
  logic [15:0] t_rd_data, t_cmd;

  int checks = 0;
  int errors = 0;

  spi_arb #(.GAP_CYC(4), .TMO_CYC(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rd_data(rd_data),
    .tmo_err(tmo_err), .wrt(wrt), .cmd(cmd), .mstr_done(mstr_done),
    .mstr_rd_data(mstr_rd_data), .mstr_SS_n(mstr_SS_n), .SS0_n(SS0_n), .SS1_n(SS1_n)
  );

  spi_arb #(.GAP_CYC(4), .TMO_CYC(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1), .rd_data(t_rd_data),
    .tmo_err(t_tmo_err), .wrt(t_wrt), .cmd(t_cmd), .mstr_done(mstr_done),
    .mstr_rd_data(mstr_rd_data), .mstr_SS_n(mstr_SS_n), .SS0_n(t_SS0_n), .SS1_n(t_SS1_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1;
    logic [15:0] c0, c1;
    logic        md;
    logic [15:0] mdat;
    logic        ms;
    logic [6:0]  eflg;   // {gnt0,gnt1,wrt,done0,done1,SS0_n,SS1_n}
    logic [15:0] ecmd, erd;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mkv(input logic r0, input logic r1, input logic [15:0] c0,
                               input logic [15:0] c1, input logic md, input logic [15:0] mdat,
                               input logic ms, input logic [6:0] eflg,
                               input logic [15:0] ecmd, input logic [15:0] erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1; v.md = md; v.mdat = mdat;
    v.ms = ms; v.eflg = eflg; v.ecmd = ecmd; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; returns in the first cycle with rst_n high (IDLE).
  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; mstr_done = 1'b0; mstr_SS_n = 1'b1;
    mstr_rd_data = 16'h0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Start in an IDLE cycle: request, drop after grant, master done dly cycles
  // after the wrt cycle; returns (settled) in the done cycle.
  task automatic xact(input logic who, input logic [15:0] c, input int dly, input logic [15:0] d);
    if (who) begin req1 = 1'b1; cmd1 = c; end
    else     begin req0 = 1'b1; cmd0 = c; end
    step();                       // LAUNCH, gnt visible
    req0 = 1'b0; req1 = 1'b0;
    step();                       // first XFER cycle, wrt visible
    mstr_SS_n = 1'b0;
    for (int i = 0; i < dly; i++) step();
    mstr_done = 1'b1; mstr_rd_data = d;
    step();
    mstr_done = 1'b0; mstr_SS_n = 1'b1;
    #1;
  endtask

  initial begin
    cmd0 = 16'h0000; cmd1 = 16'h0000;

    // Tie after reset, GAP enforcement, then a second tie; one row per cycle.
    vt[0]  = mkv(1'b1, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'h0000, 16'h0000);
    vt[1]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b1000011, 16'hA200, 16'h0000);
    vt[2]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b0, 7'b0010001, 16'hA200, 16'h0000);
    vt[3]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b1, 16'h1111, 1'b0, 7'b0000001, 16'hA200, 16'h0000);
    vt[4]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0001011, 16'hA200, 16'h1111);
    vt[5]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hA200, 16'h1111);
    vt[6]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hA200, 16'h1111);
    vt[7]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hA200, 16'h1111);
    vt[8]  = mkv(1'b0, 1'b1, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hA200, 16'h1111);
    vt[9]  = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0100011, 16'hB300, 16'h1111);
    vt[10] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b0, 7'b0010010, 16'hB300, 16'h1111);
    vt[11] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b1, 16'h2222, 1'b0, 7'b0000010, 16'hB300, 16'h1111);
    vt[12] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000111, 16'hB300, 16'h2222);
    vt[13] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hB300, 16'h2222);
    vt[14] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hB300, 16'h2222);
    vt[15] = mkv(1'b0, 1'b0, 16'hA200, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hB300, 16'h2222);
    vt[16] = mkv(1'b1, 1'b1, 16'hC400, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b0000011, 16'hB300, 16'h2222);
    vt[17] = mkv(1'b0, 1'b1, 16'hC400, 16'hB300, 1'b0, 16'h0000, 1'b1, 7'b1000011, 16'hC400, 16'h2222);
    vt[18] = mkv(1'b0, 1'b1, 16'hC400, 16'hB300, 1'b0, 16'h0000, 1'b0, 7'b0010001, 16'hC400, 16'h2222);

    // Reset values.
    do_reset();
    #1;
    chk("rst flags", {9'b0, gnt0, gnt1, wrt, done0, done1, SS0_n, SS1_n}, 16'h0003);
    chk("rst cmd", cmd, 16'h0000);
    chk("rst rd_data", rd_data, 16'h0000);
    chk1("rst tmo_err", tmo_err, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step();
      req0 = vt[i].r0; req1 = vt[i].r1; cmd0 = vt[i].c0; cmd1 = vt[i].c1;
      mstr_done = vt[i].md; mstr_rd_data = vt[i].mdat; mstr_SS_n = vt[i].ms;
      #1;
      chk($sformatf("row%0d flags", i),
          {9'b0, gnt0, gnt1, wrt, done0, done1, SS0_n, SS1_n}, {9'b0, vt[i].eflg});
      chk($sformatf("row%0d cmd", i), cmd, vt[i].ecmd);
      chk($sformatf("row%0d rd_data", i), rd_data, vt[i].erd);
    end

    // Single request with a 40-cycle master transfer.
    do_reset();
    req0 = 1'b1; cmd0 = 16'hA200;
    step(); #1;
    chk1("single gnt0", gnt0, 1'b1);
    chk1("single gnt1", gnt1, 1'b0);
    req0 = 1'b0;
    step(); #1;
    chk1("single wrt", wrt, 1'b1);
    chk("single cmd", cmd, 16'hA200);
    mstr_SS_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 40) begin mstr_done = 1'b1; mstr_rd_data = 16'h5A00; end
      #1;
      chk1($sformatf("single wait%0d done0", i), done0, 1'b0);
      chk1($sformatf("single wait%0d SS1_n", i), SS1_n, 1'b1);
      if (i == 1) chk1("single wrt once", wrt, 1'b0);
      if (i == 20) chk1("single SS0_n", SS0_n, 1'b0);
    end
    step();
    mstr_done = 1'b0; mstr_SS_n = 1'b1;
    #1;
    chk1("single done0", done0, 1'b1);
    chk1("single done1", done1, 1'b0);
    chk("single rd_data", rd_data, 16'h5A00);
    chk1("single SS1_n end", SS1_n, 1'b1);

    // Timeout on the TMO_CYC=16 instance, bracketed by good transactions.
    do_reset();
    xact(1'b1, 16'h7777, 2, 16'h3C3C);
    chk1("tmo pre done1", t_done1, 1'b1);
    chk("tmo pre rd_data", t_rd_data, 16'h3C3C);
    repeat (4) step();
    req0 = 1'b1; cmd0 = 16'h1234;
    step(); #1;
    chk1("tmo gnt0", t_gnt0, 1'b1);
    req0 = 1'b0;
    step(); #1;
    chk1("tmo wrt", t_wrt, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step(); #1;
      chk1($sformatf("tmo wait%0d done0", k), t_done0, 1'b0);
    end
    step(); #1;
    chk1("tmo done0", t_done0, 1'b1);
    chk("tmo rd_data", t_rd_data, 16'h0000);
    chk1("tmo tmo_err", t_tmo_err, 1'b1);
    repeat (4) step();
    xact(1'b1, 16'h5555, 3, 16'hABCD);
    chk1("tmo post done1", t_done1, 1'b1);
    chk("tmo post rd_data", t_rd_data, 16'hABCD);
    chk1("tmo sticky", t_tmo_err, 1'b1);

    // Master done lands exactly on the timeout cycle (counter = 15).
    do_reset();
    xact(1'b0, 16'h0F0F, 15, 16'h9999);
    chk1("simul done0", t_done0, 1'b1);
    chk("simul rd_data", t_rd_data, 16'h9999);
    chk1("simul tmo_err", t_tmo_err, 1'b0);

    // One-cycle reset 10 cycles into XFER with req0 held throughout.
    do_reset();
    req0 = 1'b1; cmd0 = 16'hA5A5;
    step();
    step();
    mstr_SS_n = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rstx flags", {9'b0, gnt0, gnt1, wrt, done0, done1, SS0_n, SS1_n}, 16'h0003);
    chk("rstx cmd", cmd, 16'h0000);
    chk("rstx rd_data", rd_data, 16'h0000);
    chk1("rstx tmo_err", tmo_err, 1'b0);
    step(); #1;
    chk1("rstx regrant", gnt0, 1'b1);
    chk1("rstx no done", done0, 1'b0);
    chk("rstx cmd2", cmd, 16'hA5A5);
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
